// File: rtl/pld_pkg.sv
// Shared PLD fuse-map geometry and programmer state encoding.
// PLD_FUSE_PROG_CHECKSUM_EN adds the CHECK state used by the checksum-verified load.
package pld_pkg;

`ifdef PLD_FUSE_PROG_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } pld_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd3
    } pld_state_e;
`endif

    function automatic int pld_and_fuses(input int n);
        return (2 ** (n + 2)) * (n ** 2);
    endfunction

    function automatic int pld_or_fuses(input int n, input int m);
        return m * (2 ** (2 * n));
    endfunction

    function automatic int pld_num_words(input int n, input int m, input int w);
        return (pld_and_fuses(n) + pld_or_fuses(n, m) + w - 1) / w;
    endfunction

endpackage

// File: rtl/pld_fuse_programmer.sv
// Word-serial fuse bitstream loader with atomic commit of AND/OR fuse vectors.
// Define PLD_FUSE_PROG_CHECKSUM_EN to require a trailing XOR checksum word before commit.
module pld_fuse_programmer
    import pld_pkg::*;
#(
    parameter int  NUM_PORTS_IN  = 1,
    parameter int  NUM_PORTS_OUT = 1,
    parameter int  DATA_WIDTH    = 8,
    localparam int AND_FUSES     = pld_and_fuses(NUM_PORTS_IN),
    localparam int OR_FUSES      = pld_or_fuses(NUM_PORTS_IN, NUM_PORTS_OUT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  conf_valid_o,
    output logic [AND_FUSES-1:0]  and_matrix_fuses_conf_o,
    output logic [OR_FUSES-1:0]   or_matrix_fuses_conf_o
);

    localparam int TOTAL_FUSES = AND_FUSES + OR_FUSES;
    localparam int NUM_WORDS   = pld_num_words(NUM_PORTS_IN, NUM_PORTS_OUT, DATA_WIDTH);
    localparam int SHW         = NUM_WORDS * DATA_WIDTH;
    localparam int CW          = $clog2(NUM_WORDS + 1);

    pld_state_e             state_q, state_d;
    logic [CW-1:0]          word_cnt;
    logic [SHW-1:0]         shadow;
    logic [SHW-1:0]         stream;
    logic [AND_FUSES-1:0]   and_q;
    logic [OR_FUSES-1:0]    or_q;
    logic                   conf_valid_q;
    logic                   xfer;
    logic                   last_word;
    logic                   commit;
    logic                   csum_fail;

`ifdef PLD_FUSE_PROG_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  csum_q;
    logic                   error_q;
`endif

    assign xfer      = valid_i && ready_o && !abort_i;
    assign last_word = (word_cnt == CW'(NUM_WORDS - 1));

    // Shadow with the in-flight word merged in, so the last word commits at its own edge.
    always_comb begin
        stream = shadow;
        if (state_q == ST_LOAD)
            stream[int'(word_cnt) * DATA_WIDTH +: DATA_WIDTH] = data_i;
    end

    always_comb begin
        state_d   = state_q;
        ready_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        commit    = 1'b0;
        csum_fail = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ready_o = 1'b1;
                busy_o  = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (valid_i && last_word) begin
`ifdef PLD_FUSE_PROG_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
                    commit  = 1'b1;
`endif
                end
            end
`ifdef PLD_FUSE_PROG_CHECKSUM_EN
            ST_CHECK: begin
                ready_o = 1'b1;
                busy_o  = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (valid_i) begin
                    if (data_i == csum_q) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        csum_fail = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            word_cnt     <= '0;
            shadow       <= '0;
            and_q        <= '0;
            or_q         <= '0;
            conf_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start_i && !abort_i) begin
                word_cnt <= '0;
                shadow   <= '0;
            end
            if (state_q == ST_LOAD && xfer) begin
                shadow   <= stream;
                word_cnt <= word_cnt + 1'b1;
            end
            if (commit) begin
                and_q        <= stream[AND_FUSES-1:0];
                or_q         <= stream[TOTAL_FUSES-1:AND_FUSES];
                conf_valid_q <= 1'b1;
            end
        end
    end

`ifdef PLD_FUSE_PROG_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csum_q  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start_i && !abort_i) begin
                csum_q  <= '0;
                error_q <= 1'b0;
            end
            if (state_q == ST_LOAD && xfer)
                csum_q <= csum_q ^ data_i;
            if (csum_fail)
                error_q <= 1'b1;
        end
    end
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    assign conf_valid_o            = conf_valid_q;
    assign and_matrix_fuses_conf_o = and_q;
    assign or_matrix_fuses_conf_o  = or_q;

endmodule

// File: tb/tb_pld_fuse_programmer.sv
// Directed bench for pld_fuse_programmer at N=1, M=1, W=8 (AND=8, OR=4, 2 words).
// Also exercises the checksum path when PLD_FUSE_PROG_CHECKSUM_EN is defined.
module tb_pld_fuse_programmer;

    logic       clk = 1'b0;
    logic       rst, start, abort, valid;
    logic [7:0] data;
    logic       ready, busy, done, error, conf_valid;
    logic [7:0] and_f;
    logic [3:0] or_f;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    pld_fuse_programmer #(.NUM_PORTS_IN(1), .NUM_PORTS_OUT(1), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .data_i(data), .valid_i(valid), .ready_o(ready), .busy_o(busy),
        .done_o(done), .error_o(error), .conf_valid_o(conf_valid),
        .and_matrix_fuses_conf_o(and_f), .or_matrix_fuses_conf_o(or_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d);
        valid = 1'b1;
        data  = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checksum word for checksum builds; nothing to send otherwise.
    task automatic close_session(input logic [7:0] csum);
`ifdef PLD_FUSE_PROG_CHECKSUM_EN
        send_word(csum);
`else
        if (csum === 8'hxx) data = 8'h00;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if ({and_f, or_f, conf_valid, ready, busy, done, error} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs got and=%h or=%h cv=%b rdy=%b busy=%b done=%b err=%b want all 0",
                     and_f, or_f, conf_valid, ready, busy, done, error);
        end
    endtask

    task automatic test_commit();
        begin_session();
        checks++;
        if (ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL load_flags got rdy=%b busy=%b want 1 1", ready, busy);
        end
        send_word(8'hA5);
        checks++;
        if (conf_valid !== 1'b0 || and_f !== 8'h00) begin
            errors++; $display("FAIL no_partial_commit got cv=%b and=%h want 0 00", conf_valid, and_f);
        end
        send_word(8'hF3);
        close_session(8'h56);
        checks++;
        if (and_f !== 8'hA5 || or_f !== 4'h3 || conf_valid !== 1'b1) begin
            errors++; $display("FAIL commit_value got and=%h or=%h cv=%b want a5 3 1", and_f, or_f, conf_valid);
        end
        checks++;
        if (done !== 1'b1 || ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL done_state got done=%b rdy=%b busy=%b want 1 0 1", done, ready, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_abort();
        begin_session();
        send_word(8'h11);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b rdy=%b done=%b want 0 0 0", busy, ready, done);
        end
        send_word(8'hFF);
        checks++;
        if (and_f !== 8'hA5 || or_f !== 4'h3 || conf_valid !== 1'b1) begin
            errors++; $display("FAIL abort_keeps_conf got and=%h or=%h cv=%b want a5 3 1", and_f, or_f, conf_valid);
        end
        // Abort coinciding with a handshake must not accept the word.
        begin_session();
        valid = 1'b1; data = 8'h22; abort = 1'b1;
        tick();
        valid = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || and_f !== 8'hA5) begin
            errors++; $display("FAIL abort_with_xfer got busy=%b and=%h want 0 a5", busy, and_f);
        end
        begin_session();
        send_word(8'h5A);
        send_word(8'h0C);
        close_session(8'h56);
        checks++;
        if (and_f !== 8'h5A || or_f !== 4'hC || done !== 1'b1) begin
            errors++; $display("FAIL fresh_after_abort got and=%h or=%h done=%b want 5a c 1", and_f, or_f, done);
        end
        tick();
    endtask

    task automatic test_stall();
        int bad = 0;
        begin_session();
        send_word(8'h3C);
        repeat (10) begin
            tick();
            if (ready !== 1'b1 || conf_valid !== 1'b1 || and_f !== 8'h5A) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad);
        end
        send_word(8'h07);
        close_session(8'h3B);
        checks++;
        if (and_f !== 8'h3C || or_f !== 4'h7 || done !== 1'b1) begin
            errors++; $display("FAIL stall_commit got and=%h or=%h done=%b want 3c 7 1", and_f, or_f, done);
        end
        // start held through DONE: DONE still exits to IDLE.
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL start_in_done got busy=%b rdy=%b want 0 0", busy, ready);
        end
    endtask

    task automatic test_start_abort();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL start_abort_idle got rdy=%b busy=%b want 0 0", ready, busy);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++; $display("FAIL error_low got %b want 0", error);
        end
    endtask

    task automatic test_checksum();
`ifdef PLD_FUSE_PROG_CHECKSUM_EN
        begin_session();
        send_word(8'hA5);
        send_word(8'h03);
        checks++;
        if (ready !== 1'b1 || and_f !== 8'h3C) begin
            errors++; $display("FAIL check_state got rdy=%b and=%h want 1 3c", ready, and_f);
        end
        send_word(8'hA6);
        checks++;
        if (and_f !== 8'hA5 || or_f !== 4'h3 || done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL csum_match got and=%h or=%h done=%b err=%b want a5 3 1 0", and_f, or_f, done, error);
        end
        tick();
        begin_session();
        send_word(8'h00);
        send_word(8'h01);
        send_word(8'h00);
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || and_f !== 8'hA5 || or_f !== 4'h3) begin
            errors++; $display("FAIL csum_mismatch got err=%b done=%b busy=%b and=%h or=%h want 1 0 0 a5 3",
                               error, done, busy, and_f, or_f);
        end
        begin_session();
        checks++;
        if (error !== 1'b0) begin
            errors++; $display("FAIL error_clear got %b want 0", error);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_commit();
        test_abort();
        test_stall();
        test_start_abort();
        test_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pld_fuse_programmer.md
Name: pld_fuse_programmer

Overview:
- Writer side of the PLD fuse-configuration interface.
- Accepts a word-serial fuse bitstream over a valid/ready stream and assembles it in a shadow register.
- Commits the AND-matrix and OR-matrix fuse vectors atomically to the PLD's configuration inputs.
- The PLD never sees a partially loaded configuration; the previously committed configuration stays live until a full new one is accepted.

Parameters:
- NUM_PORTS_IN, 1, N: PLD input count.
- NUM_PORTS_OUT, 1, M: PLD output count.
- DATA_WIDTH, 8, W: stream word width in bits.
- Derived, not overridable: AND_FUSES = (2**(N+2))*(N**2); OR_FUSES = M*(2**(2*N)); TOTAL_FUSES = AND_FUSES+OR_FUSES; NUM_WORDS = ceil(TOTAL_FUSES/W).

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  begin a programming session; sampled in IDLE only.
- abort_i  in  1  abandon the session in progress.
- data_i  in  W  bitstream word.
- valid_i  in  1  data_i valid.
- ready_o  out  1  programmer can accept a word.
- busy_o  out  1  a session is in progress.
- done_o  out  1  one-cycle pulse on commit.
- error_o  out  1  checksum failure, sticky; see Optional Feature.
- conf_valid_o  out  1  at least one configuration has been committed since reset.
- and_matrix_fuses_conf_o  out  AND_FUSES  committed AND fuse vector.
- or_matrix_fuses_conf_o  out  OR_FUSES  committed OR fuse vector.

Behaviour:
- Reset (rst_i high at an edge):
  - State goes to IDLE.
  - All outputs go to 0, including both fuse vectors and conf_valid_o.
  - The shadow register and word counter are cleared.
  - Reset mid-session discards the session.
- States: IDLE, LOAD, CHECK (only with the macro), DONE.
- IDLE: ready_o=0, busy_o=0. If start_i=1 and abort_i=0: word_cnt<=0, error_o<=0, go to LOAD. If start_i and abort_i are both 1, abort wins and the state stays IDLE.
- LOAD:
  - ready_o=1, busy_o=1.
  - A transfer occurs on an edge where valid_i && ready_o.
  - Word k, bit b maps to stream bit k*W+b.
  - Stream bits [AND_FUSES-1:0] map to and_matrix_fuses_conf, bit for bit.
  - Stream bits [TOTAL_FUSES-1:AND_FUSES] map to or_matrix_fuses_conf[OR_FUSES-1:0].
  - Padding bits at positions >= TOTAL_FUSES are ignored.
  - start_i is ignored in LOAD.
  - valid_i low stalls the session indefinitely with no timeout.
- Last word (word_cnt == NUM_WORDS-1), macro disabled:
  - At the same edge, shadow plus the incoming word is written to both output vectors and conf_valid_o<=1.
  - State goes to DONE.
  - Latency is 0 cycles after the final handshake edge: the outputs change at that edge.
- DONE: done_o=1, ready_o=0, busy_o=1 for exactly one cycle, then IDLE. A start_i seen in DONE is ignored.
- abort_i in LOAD or CHECK:
  - Go to IDLE at the next edge.
  - The shadow is discarded and the outputs are unchanged.
  - If abort_i coincides with a handshake, the word is not accepted.
- word_cnt width is $clog2(NUM_WORDS+1) and never wraps within a session.

Optional Feature:
- Macro: PLD_FUSE_PROG_CHECKSUM_EN.
- Enabled:
  - After word NUM_WORDS-1 is accepted, the state goes to CHECK without committing.
  - In CHECK, ready_o=1 and one further word is accepted: the XOR of all NUM_WORDS data words, padding bits included.
  - On match: commit, go to DONE (behaviour as above).
  - On mismatch: error_o<=1, no commit, outputs unchanged, go to IDLE, no done_o pulse.
  - error_o clears on the next accepted start_i.
- Disabled: the CHECK state and checksum logic are absent, and error_o is tied to 0.

Decomposition:
- Package pld_pkg holds:
  - the state enum;
  - functions pld_and_fuses(n), pld_or_fuses(n,m), pld_num_words(n,m,w);
  - so the PLD and the programmer share identical width formulas.
- No sub-module is warranted. Keep the block flat: FSM, word counter, shadow register, optional XOR accumulator.

Test Plan (N=1, M=1, W=8: AND_FUSES=8, OR_FUSES=4, NUM_WORDS=2):
- Reset, then idle 5 cycles -> both fuse vectors 0, conf_valid_o=0, ready_o=0, busy_o=0.
- start_i, then words 0xA5 and 0xF3 with valid held high -> at the second handshake edge AND=8'hA5, OR=4'h3 (padding 0xF0 ignored), done_o pulses for 1 cycle, conf_valid_o=1.
- Commit AND=0xA5/OR=0x3, then start a session, send 0x11, then assert abort_i -> outputs still 0xA5/0x3, state IDLE, no done_o.
- Stall: valid_i low for 10 cycles between the two words -> ready_o stays 1 and the commit happens only after the second word.
- Macro on: words 0xA5, 0x03, checksum 0xA6 -> commit AND=0xA5, OR=0x3. Same words with checksum 0x00 -> error_o=1, outputs unchanged, no done_o; the next start clears error_o.
- start_i and abort_i both high in IDLE -> stays IDLE, ready_o=0.
